// File: rtl/tlb_access_ctrl_pkg.sv
// Shared types and constants for the TLB access sequencer.
package tlb_access_ctrl_pkg;

    // Virtual address width for SV39 translation.
    localparam int VLEN = 39;

    // Requester indices into the req_* vectors.
    localparam int REQ_ITLB = 0;
    localparam int REQ_DTLB = 1;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,  // lookups permitted, no walk outstanding
        WALK  = 2'd1,  // walk outstanding, hit-under-miss lookups permitted
        DRAIN = 2'd2,  // flush waiting for the outstanding walk to finish
        FLUSH = 2'd3   // single-cycle TLB flush
    } state_e;

    // Select the granted requester's address; zero when nothing is granted.
    function automatic logic [VLEN-1:0] sel_vaddr(input logic [2*VLEN-1:0] vaddrs,
                                                  input logic [1:0]        gnt);
        logic [VLEN-1:0] sel;
        sel = '0;
        if (gnt[REQ_DTLB]) begin
            sel = vaddrs[REQ_DTLB*VLEN +: VLEN];
        end else if (gnt[REQ_ITLB]) begin
            sel = vaddrs[REQ_ITLB*VLEN +: VLEN];
        end
        return sel;
    endfunction

endpackage

// File: rtl/tlb_access_ctrl_rr_arbiter.sv
// Two-way round-robin arbiter with enable and one-hot grant.
// The pointer names the requester that wins the next contested cycle.
module tlb_rr_arbiter
    import tlb_access_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic rr_q;

    // Grant selection: a lone requester always wins, a tie goes to rr_q.
    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = rr_q ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Pointer update: after a contested grant, the loser gets the next tie.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= 1'b1;  // data side first out of reset
        end else if (en && (req == 2'b11)) begin
            rr_q <= ~rr_q;
        end
    end

endmodule

// File: rtl/tlb_access_ctrl.sv
// Front end for the shared SV39 TLB: arbitrates I/D lookups onto one port,
// launches a single page-table walk on a miss, and serialises flushes so they
// never overlap a walk or a lookup.
module tlb_access_ctrl
    import tlb_access_ctrl_pkg::*;
#(
    parameter int ASID_WIDTH = 1,
    parameter int VMID_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // lookup requesters
    input  logic [1:0]            req_valid_i,
    input  logic [2*VLEN-1:0]     req_vaddr_i,
    output logic [1:0]            req_ready_o,
    output logic [1:0]            resp_valid_o,
    output logic                  resp_hit_o,
    // TLB lookup port
    output logic                  lu_access_o,
    output logic [VLEN-1:0]       lu_vaddr_o,
    input  logic                  lu_hit_i,
    // page-table walker
    output logic                  walk_req_o,
    output logic [VLEN-1:0]       walk_vaddr_o,
    input  logic                  walk_done_i,
    // flush request
    input  logic                  flush_req_i,
    input  logic [ASID_WIDTH-1:0] flush_asid_i,
    input  logic [VMID_WIDTH-1:0] flush_vmid_i,
    input  logic [VLEN-1:0]       flush_vaddr_i,
    // TLB flush port
    output logic                  tlb_flush_o,
    output logic [ASID_WIDTH-1:0] tlb_flush_asid_o,
    output logic [VMID_WIDTH-1:0] tlb_flush_vmid_o,
    output logic [VLEN-1:0]       tlb_flush_vaddr_o,
    output logic                  flush_ack_o
);

    state_e     state_q;
    logic       grant_en;
    logic [1:0] gnt;
    logic       lookup_states;
    logic       flush_capture;
    logic       miss;

    // Lookups run in IDLE and WALK only; a pending flush blocks them in its
    // request cycle, and reset forces the grant low.
    assign lookup_states = (state_q == IDLE) || (state_q == WALK);
    assign grant_en      = lookup_states && !flush_req_i && !rst_i;

    // Flush operands are sampled in the cycle a flush is accepted.
    assign flush_capture = lookup_states && flush_req_i;

    tlb_rr_arbiter u_arb (
        .clk (clk_i),
        .rst (rst_i),
        .en  (grant_en),
        .req (req_valid_i),
        .gnt (gnt)
    );

    assign req_ready_o = gnt;
    assign lu_access_o = |gnt;
    assign lu_vaddr_o  = sel_vaddr(req_vaddr_i, gnt);
    assign miss        = lu_access_o && !lu_hit_i;

    // Sequencer FSM with registered response, walk and flush strobes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            resp_valid_o <= 2'b00;
            resp_hit_o   <= 1'b0;
            walk_req_o   <= 1'b0;
            walk_vaddr_o <= '0;
            tlb_flush_o  <= 1'b0;
            flush_ack_o  <= 1'b0;
        end else begin
            // Every granted lookup answers exactly one cycle later.
            resp_valid_o <= gnt;
            resp_hit_o   <= lu_access_o && lu_hit_i;
            walk_req_o   <= 1'b0;
            tlb_flush_o  <= 1'b0;
            flush_ack_o  <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (flush_req_i) begin
                        state_q     <= FLUSH;
                        tlb_flush_o <= 1'b1;
                        flush_ack_o <= 1'b1;
                    end else if (miss) begin
                        // Only a miss seen with no walk in flight starts one.
                        state_q      <= WALK;
                        walk_req_o   <= 1'b1;
                        walk_vaddr_o <= lu_vaddr_o;
                    end
                end
                WALK: begin
                    // Misses here respond hit=0 and are retried by the requester.
                    if (flush_req_i && walk_done_i) begin
                        state_q     <= FLUSH;
                        tlb_flush_o <= 1'b1;
                        flush_ack_o <= 1'b1;
                    end else if (flush_req_i) begin
                        state_q <= DRAIN;
                    end else if (walk_done_i) begin
                        state_q <= IDLE;
                    end
                end
                DRAIN: begin
                    if (walk_done_i) begin
                        state_q     <= FLUSH;
                        tlb_flush_o <= 1'b1;
                        flush_ack_o <= 1'b1;
                    end
                end
                FLUSH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Flush operand registers, loaded when a flush is accepted and held until
    // the next one so the TLB sees stable operands with the strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tlb_flush_asid_o  <= '0;
            tlb_flush_vmid_o  <= '0;
            tlb_flush_vaddr_o <= '0;
        end else if (flush_capture) begin
            tlb_flush_asid_o  <= flush_asid_i;
            tlb_flush_vmid_o  <= flush_vmid_i;
            tlb_flush_vaddr_o <= flush_vaddr_i;
        end
    end

endmodule

// File: tb/tb_tlb_access_ctrl.sv
// Directed scoreboard bench for tlb_access_ctrl: the stimulus process pushes
// expected responses, walks and flushes; a negedge monitor pops and compares.
module tb_tlb_access_ctrl;
    import tlb_access_ctrl_pkg::*;

    localparam int AW = 4;
    localparam int VW = 2;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [1:0]      req_valid_i;
    logic [2*VLEN-1:0] req_vaddr_i;
    logic [1:0]      req_ready_o;
    logic [1:0]      resp_valid_o;
    logic            resp_hit_o;
    logic            lu_access_o;
    logic [VLEN-1:0] lu_vaddr_o;
    logic            lu_hit_i;
    logic            walk_req_o;
    logic [VLEN-1:0] walk_vaddr_o;
    logic            walk_done_i;
    logic            flush_req_i;
    logic [AW-1:0]   flush_asid_i;
    logic [VW-1:0]   flush_vmid_i;
    logic [VLEN-1:0] flush_vaddr_i;
    logic            tlb_flush_o;
    logic [AW-1:0]   tlb_flush_asid_o;
    logic [VW-1:0]   tlb_flush_vmid_o;
    logic [VLEN-1:0] tlb_flush_vaddr_o;
    logic            flush_ack_o;

    logic [VLEN-1:0] vaddr_i;
    logic [VLEN-1:0] vaddr_d;
    assign req_vaddr_i = {vaddr_d, vaddr_i};

    typedef struct {
        logic [1:0] v;
        logic       hit;
    } resp_t;

    typedef struct {
        logic [AW-1:0]   asid;
        logic [VW-1:0]   vmid;
        logic [VLEN-1:0] vaddr;
    } flush_t;

    resp_t           resp_q[$];
    logic [VLEN-1:0] walk_q[$];
    flush_t          flush_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    tlb_access_ctrl #(
        .ASID_WIDTH (AW),
        .VMID_WIDTH (VW)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .req_valid_i       (req_valid_i),
        .req_vaddr_i       (req_vaddr_i),
        .req_ready_o       (req_ready_o),
        .resp_valid_o      (resp_valid_o),
        .resp_hit_o        (resp_hit_o),
        .lu_access_o       (lu_access_o),
        .lu_vaddr_o        (lu_vaddr_o),
        .lu_hit_i          (lu_hit_i),
        .walk_req_o        (walk_req_o),
        .walk_vaddr_o      (walk_vaddr_o),
        .walk_done_i       (walk_done_i),
        .flush_req_i       (flush_req_i),
        .flush_asid_i      (flush_asid_i),
        .flush_vmid_i      (flush_vmid_i),
        .flush_vaddr_i     (flush_vaddr_i),
        .tlb_flush_o       (tlb_flush_o),
        .tlb_flush_asid_o  (tlb_flush_asid_o),
        .tlb_flush_vmid_o  (tlb_flush_vmid_o),
        .tlb_flush_vaddr_o (tlb_flush_vaddr_o),
        .flush_ack_o       (flush_ack_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One stimulus cycle: drive inputs, check the combinational grant and
    // record the response the monitor should see one cycle later.
    task automatic cyc(input logic [1:0] v, input logic hit, input logic done,
                       input logic fl, input logic [1:0] exp_gnt);
        @(posedge clk_i);
        #1;
        req_valid_i = v;
        lu_hit_i    = hit;
        walk_done_i = done;
        flush_req_i = fl;
        #2;
        check("req_ready", 64'(req_ready_o), 64'(exp_gnt));
        check("lu_access", 64'(lu_access_o), 64'(exp_gnt != 2'b00));
        if (exp_gnt != 2'b00) begin
            check("lu_vaddr", 64'(lu_vaddr_o), 64'(exp_gnt[1] ? vaddr_d : vaddr_i));
            resp_q.push_back('{v: exp_gnt, hit: hit});
        end
    endtask

    task automatic push_flush();
        flush_q.push_back('{asid: flush_asid_i, vmid: flush_vmid_i, vaddr: flush_vaddr_i});
    endtask

    // Monitor: every registered strobe must match the head of its queue.
    initial begin
        resp_t           r;
        flush_t          f;
        logic [VLEN-1:0] w;
        forever begin
            @(negedge clk_i);
            if (rst_i === 1'b0) begin
                if (resp_valid_o != 2'b00) begin
                    if (resp_q.size() == 0) begin
                        check("resp_unexpected", 64'(resp_valid_o), 64'd0);
                    end else begin
                        r = resp_q.pop_front();
                        check("resp_valid", 64'(resp_valid_o), 64'(r.v));
                        check("resp_hit", 64'(resp_hit_o), 64'(r.hit));
                    end
                end
                if (walk_req_o) begin
                    if (walk_q.size() == 0) begin
                        check("walk_unexpected", 64'(walk_req_o), 64'd0);
                    end else begin
                        w = walk_q.pop_front();
                        check("walk_vaddr", 64'(walk_vaddr_o), 64'(w));
                    end
                end
                if (tlb_flush_o || flush_ack_o) begin
                    check("flush_ack_with_flush", 64'({tlb_flush_o, flush_ack_o}), 64'd3);
                    if (flush_q.size() == 0) begin
                        check("flush_unexpected", 64'(tlb_flush_o), 64'd0);
                    end else begin
                        f = flush_q.pop_front();
                        check("flush_asid", 64'(tlb_flush_asid_o), 64'(f.asid));
                        check("flush_vmid", 64'(tlb_flush_vmid_o), 64'(f.vmid));
                        check("flush_vaddr", 64'(tlb_flush_vaddr_o), 64'(f.vaddr));
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i         = 1'b1;
        req_valid_i   = 2'b11;
        lu_hit_i      = 1'b0;
        walk_done_i   = 1'b0;
        flush_req_i   = 1'b0;
        flush_asid_i  = '0;
        flush_vmid_i  = '0;
        flush_vaddr_i = '0;
        vaddr_i       = 39'h0_0000_1000;
        vaddr_d       = 39'h0_0000_2000;

        // Reset state: registered outputs low, grants blocked even with requests.
        @(posedge clk_i);
        #2;
        check("rst_req_ready", 64'(req_ready_o), 64'd0);
        check("rst_lu_access", 64'(lu_access_o), 64'd0);
        check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        check("rst_walk_req", 64'(walk_req_o), 64'd0);
        check("rst_tlb_flush", 64'(tlb_flush_o), 64'd0);
        check("rst_flush_ack", 64'(flush_ack_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i       = 1'b0;
        req_valid_i = 2'b00;

        // Both requesters with hits: D, I, D, I.
        cyc(2'b11, 1'b1, 1'b0, 1'b0, 2'b10);
        cyc(2'b11, 1'b1, 1'b0, 1'b0, 2'b01);
        cyc(2'b11, 1'b1, 1'b0, 1'b0, 2'b10);
        cyc(2'b11, 1'b1, 1'b0, 1'b0, 2'b01);
        cyc(2'b00, 1'b0, 1'b0, 1'b0, 2'b00);

        // I-side miss launches a walk; D-side hits still granted during WALK.
        vaddr_i = 39'h0_4000_1000;
        walk_q.push_back(39'h0_4000_1000);
        cyc(2'b01, 1'b0, 1'b0, 1'b0, 2'b01);
        cyc(2'b10, 1'b1, 1'b0, 1'b0, 2'b10);
        check("walk_vaddr_held_1", 64'(walk_vaddr_o), 64'h4000_1000);
        cyc(2'b10, 1'b1, 1'b0, 1'b0, 2'b10);
        check("walk_vaddr_held_2", 64'(walk_vaddr_o), 64'h4000_1000);

        // Second miss during WALK: hit=0 response, no extra walk.
        cyc(2'b01, 1'b0, 1'b0, 1'b0, 2'b01);
        check("walk_vaddr_held_3", 64'(walk_vaddr_o), 64'h4000_1000);

        // Flush in WALK, walk_done 5 cycles later; operands changed after capture.
        flush_asid_i  = 4'h9;
        flush_vmid_i  = 2'h2;
        flush_vaddr_i = 39'h0_0ABC_D000;
        push_flush();
        cyc(2'b11, 1'b1, 1'b0, 1'b1, 2'b00);
        cyc(2'b11, 1'b1, 1'b0, 1'b1, 2'b00);
        flush_asid_i  = 4'h0;
        flush_vmid_i  = 2'h0;
        flush_vaddr_i = 39'h0_0000_5555;
        cyc(2'b11, 1'b1, 1'b0, 1'b1, 2'b00);
        cyc(2'b11, 1'b1, 1'b0, 1'b1, 2'b00);
        cyc(2'b11, 1'b1, 1'b0, 1'b1, 2'b00);
        cyc(2'b11, 1'b1, 1'b1, 1'b1, 2'b00);
        cyc(2'b11, 1'b1, 1'b0, 1'b1, 2'b00);
        cyc(2'b00, 1'b0, 1'b0, 1'b0, 2'b00);

        // Flush and both requests in the same IDLE cycle: flush wins.
        flush_asid_i  = 4'h3;
        flush_vmid_i  = 2'h1;
        flush_vaddr_i = 39'h0_0000_3000;
        push_flush();
        cyc(2'b11, 1'b1, 1'b0, 1'b1, 2'b00);
        cyc(2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc(2'b11, 1'b1, 1'b0, 1'b0, 2'b10);
        cyc(2'b11, 1'b1, 1'b0, 1'b0, 2'b01);
        cyc(2'b00, 1'b0, 1'b0, 1'b0, 2'b00);

        // Move rr_q to the I side, start a D-side walk, then reset mid-walk.
        vaddr_d = 39'h0_0000_7000;
        walk_q.push_back(39'h0_0000_7000);
        cyc(2'b11, 1'b1, 1'b0, 1'b0, 2'b10);
        cyc(2'b10, 1'b0, 1'b0, 1'b0, 2'b10);
        cyc(2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc(2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
        check("walk_vaddr_before_rst", 64'(walk_vaddr_o), 64'h7000);
        @(posedge clk_i);
        #1;
        rst_i       = 1'b1;
        req_valid_i = 2'b11;
        #1;
        check("midrst_req_ready", 64'(req_ready_o), 64'd0);
        check("midrst_walk_req", 64'(walk_req_o), 64'd0);
        check("midrst_walk_vaddr", 64'(walk_vaddr_o), 64'd0);
        check("midrst_resp_valid", 64'(resp_valid_o), 64'd0);
        check("midrst_flush_vaddr", 64'(tlb_flush_vaddr_o), 64'd0);
        check("midrst_flush_ack", 64'(flush_ack_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i       = 1'b0;
        req_valid_i = 2'b00;

        // After reset the data side wins first again.
        cyc(2'b11, 1'b1, 1'b0, 1'b0, 2'b10);
        cyc(2'b11, 1'b1, 1'b0, 1'b0, 2'b01);

        // The abandoned walk is gone: a new miss starts a fresh walk.
        walk_q.push_back(39'h0_4000_1000);
        cyc(2'b01, 1'b0, 1'b0, 1'b0, 2'b01);
        cyc(2'b00, 1'b0, 1'b0, 1'b0, 2'b00);

        // walk_done with flush in WALK goes straight to FLUSH.
        flush_asid_i  = 4'hC;
        flush_vmid_i  = 2'h3;
        flush_vaddr_i = 39'h0_0000_6000;
        push_flush();
        cyc(2'b00, 1'b0, 1'b1, 1'b1, 2'b00);
        cyc(2'b00, 1'b0, 1'b0, 1'b1, 2'b00);
        cyc(2'b01, 1'b1, 1'b0, 1'b0, 2'b01);
        cyc(2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc(2'b00, 1'b0, 1'b0, 1'b0, 2'b00);

        // Every expected strobe must have been seen.
        check("resp_q_empty", 64'(resp_q.size()), 64'd0);
        check("walk_q_empty", 64'(walk_q.size()), 64'd0);
        check("flush_q_empty", 64'(flush_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
